// File: rtl/serial_frame_receiver.sv
// Serial frame deserializer: start, address, length, data, stop fields.
// Fields are sampled on clk_En ticks and delivered with a one-clk strobe.
module serial_frame_receiver #(
  parameter int ADDR_W = 3,
  parameter int LEN_W  = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_En,
  input  logic              serIn,
  output logic [DATA_W-1:0] data_out,
  output logic [ADDR_W-1:0] ch_out,
  output logic [LEN_W-1:0]  len_out,
  output logic              valid,
  output logic              frame_err,
  output logic              busy
);

  localparam int CNT_W = (ADDR_W > LEN_W) ? ADDR_W : LEN_W;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] ADDR = 3'd1;
  localparam logic [2:0] LEN  = 3'd2;
  localparam logic [2:0] DATA = 3'd3;
  localparam logic [2:0] STOP = 3'd4;

  logic [2:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr_sr;
  logic [LEN_W-1:0]  len_sr;
  logic [DATA_W-1:0] data_sr;
  logic [LEN_W-1:0]  len_nxt;
  logic              last;

  // Length value including the bit being sampled this tick.
  assign len_nxt = {len_sr[LEN_W-2:0], serIn};
  assign last    = (cnt == CNT_W'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      addr_sr   <= '0;
      len_sr    <= '0;
      data_sr   <= '0;
      data_out  <= '0;
      ch_out    <= '0;
      len_out   <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      if (clk_En) begin
        unique case (state)
          IDLE: begin
            if (!serIn) begin
              state   <= ADDR;
              busy    <= 1'b1;
              cnt     <= CNT_W'(ADDR_W);
              data_sr <= '0;
            end
          end
          ADDR: begin
            addr_sr <= {addr_sr[ADDR_W-2:0], serIn};
            cnt     <= cnt - CNT_W'(1);
            if (last) begin
              state <= LEN;
              cnt   <= CNT_W'(LEN_W);
            end
          end
          LEN: begin
            len_sr <= len_nxt;
            cnt    <= cnt - CNT_W'(1);
            if (last) begin
              if (len_nxt == '0) begin
                frame_err <= 1'b1;
                state     <= IDLE;
                busy      <= 1'b0;
              end else begin
                state <= DATA;
                cnt   <= CNT_W'(len_nxt);
              end
            end
          end
          DATA: begin
            data_sr <= {data_sr[DATA_W-2:0], serIn};
            cnt     <= cnt - CNT_W'(1);
            if (last) state <= STOP;
          end
          STOP: begin
            if (serIn) begin
              data_out <= data_sr;
              ch_out   <= addr_sr;
              len_out  <= len_sr;
              valid    <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
